// File: rtl/tpu_pkg.sv
// tpu_pkg
// Shared types and constants for the systolic-array tile controller.
// SA_DIM       : array edge length (rows, columns, K-depth per pass)
// LANE_BITS    : width of one accumulator lane
// FETCH_CYCLES : index-issue plus data-return cycles for one K-chunk
// state_t      : tile controller state encoding
// lane_slice   : pulls lane 'lane' out of a packed row (lane 0 in the MSBs)
package tpu_pkg;

    localparam int SA_DIM       = 4;
    localparam int LANE_BITS    = 32;
    localparam int ROW_BITS     = SA_DIM * LANE_BITS;
    localparam int FETCH_CYCLES = 5;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        ARM,
        RUN,
        CAPTURE,
        WRITE,
        DONE
    } state_t;

    typedef logic [LANE_BITS-1:0] lane_t;
    typedef logic [ROW_BITS-1:0]  row_t;

    // Column 0 lives in the top 32 bits of a row, so lane l sits at
    // bit offset (SA_DIM-1-l)*LANE_BITS.
    function automatic lane_t lane_slice(input row_t row, input int lane);
        return row[(SA_DIM-1-lane)*LANE_BITS +: LANE_BITS];
    endfunction

endpackage

// File: rtl/sa_tile_ctrl_if.sv
// sa_tile_ctrl_if
// Global-buffer bus between the tile controller and the A/B/C buffers.
// A_index, B_index : read indices (controller -> buffers)
// A_data_in, B_data_in : read data, one cycle after the index (buffers -> controller)
// C_wr_en, C_index, C_data_out : result row write port (controller -> buffer C)
// master : controller side, slave : buffer side
interface sa_tile_ctrl_if #(
    parameter int ADDR_BITS  = 16,
    parameter int DATA_BITS  = 32,
    parameter int DATAC_BITS = 128
);

    logic [ADDR_BITS-1:0]  A_index;
    logic [ADDR_BITS-1:0]  B_index;
    logic [DATA_BITS-1:0]  A_data_in;
    logic [DATA_BITS-1:0]  B_data_in;
    logic                  C_wr_en;
    logic [ADDR_BITS-1:0]  C_index;
    logic [DATAC_BITS-1:0] C_data_out;

    modport master (
        output A_index, B_index, C_wr_en, C_index, C_data_out,
        input  A_data_in, B_data_in
    );

    modport slave (
        input  A_index, B_index, C_wr_en, C_index, C_data_out,
        output A_data_in, B_data_in
    );

endinterface

// File: rtl/tile_accumulator.sv
// tile_accumulator
// Holds the 4x4 tile of 32-bit partial sums as four packed rows.
// clk, rst_n : clock and async active-low reset (clears the tile)
// clear      : synchronous clear of all rows
// add_en     : lane-wise add of add_row[r] into row r, modulo 2^32 per lane
// add_row    : incoming array result rows
// rd_row     : row select for the read port
// rd_data    : selected accumulated row
module tile_accumulator
    import tpu_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       add_en,
    input  row_t       add_row [SA_DIM],
    input  logic [1:0] rd_row,
    output row_t       rd_data
);

    row_t acc [SA_DIM];
    row_t sum [SA_DIM];

    // Lanes add independently; carries never cross a lane boundary.
    always_comb begin
        for (int r = 0; r < SA_DIM; r++) begin
            sum[r] = '0;
            for (int l = 0; l < SA_DIM; l++) begin
                sum[r][(SA_DIM-1-l)*LANE_BITS +: LANE_BITS] =
                    lane_slice(acc[r], l) + lane_slice(add_row[r], l);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < SA_DIM; r++) acc[r] <= '0;
        end else if (clear) begin
            for (int r = 0; r < SA_DIM; r++) acc[r] <= '0;
        end else if (add_en) begin
            for (int r = 0; r < SA_DIM; r++) acc[r] <= sum[r];
        end
    end

    assign rd_data = acc[rd_row];

endmodule

// File: rtl/sa_tile_ctrl.sv
// sa_tile_ctrl
// Drives one 4x4 output tile through the systolic array: fetches A/B words
// per K-chunk, arms and runs the array, accumulates its results and writes
// the four result rows to buffer C.
// clk, rst_n               : clock, async active-low reset
// start, k_chunks          : tile request and number of K-chunks
// a_base, b_base, c_base   : buffer base indices, latched on start
// busy, done               : tile in progress / one-cycle completion pulse
// gbuf                     : global buffer bus (A/B reads, C writes)
// sa_rst_n, sa_busy        : array reset (active-low) and busy mirror
// sa_A0..3, sa_B0..3       : operand words held for the array
// sa_done, sa_C0..3        : array pass complete and its result rows
module sa_tile_ctrl
    import tpu_pkg::*;
#(
    parameter int ADDR_BITS  = 16,
    parameter int DATA_BITS  = 32,
    parameter int DATAC_BITS = 128
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [7:0]            k_chunks,
    input  logic [ADDR_BITS-1:0]  a_base,
    input  logic [ADDR_BITS-1:0]  b_base,
    input  logic [ADDR_BITS-1:0]  c_base,
    output logic                  busy,
    output logic                  done,
    sa_tile_ctrl_if.master        gbuf,
    output logic                  sa_rst_n,
    output logic                  sa_busy,
    output logic [DATA_BITS-1:0]  sa_A0,
    output logic [DATA_BITS-1:0]  sa_A1,
    output logic [DATA_BITS-1:0]  sa_A2,
    output logic [DATA_BITS-1:0]  sa_A3,
    output logic [DATA_BITS-1:0]  sa_B0,
    output logic [DATA_BITS-1:0]  sa_B1,
    output logic [DATA_BITS-1:0]  sa_B2,
    output logic [DATA_BITS-1:0]  sa_B3,
    input  logic                  sa_done,
    input  logic [DATAC_BITS-1:0] sa_C0,
    input  logic [DATAC_BITS-1:0] sa_C1,
    input  logic [DATAC_BITS-1:0] sa_C2,
    input  logic [DATAC_BITS-1:0] sa_C3
);

    state_t               state;
    state_t               next_state;
    logic [2:0]           step;
    logic [7:0]           chunk;
    logic [7:0]           k_reg;
    logic [ADDR_BITS-1:0] a_reg;
    logic [ADDR_BITS-1:0] b_reg;
    logic [ADDR_BITS-1:0] c_reg;
    logic [DATA_BITS-1:0] op_a [SA_DIM];
    logic [DATA_BITS-1:0] op_b [SA_DIM];

    logic                 accept;
    logic                 more_chunks;
    logic [1:0]           slot;
    logic [ADDR_BITS-1:0] chunk_offset;
    row_t                 sa_rows [SA_DIM];
    row_t                 acc_row;

    assign accept       = (state == IDLE) && start;
    // Widened by one bit so k_chunks=255 cannot wrap the comparison.
    assign more_chunks  = ({1'b0, chunk} + 9'd1) < {1'b0, k_reg};
    // Data returned in fetch step s belongs to the index issued in step s-1.
    assign slot         = 2'(step - 3'd1);
    assign chunk_offset = ADDR_BITS'({chunk, 2'b00});

    assign sa_rows[0] = sa_C0;
    assign sa_rows[1] = sa_C1;
    assign sa_rows[2] = sa_C2;
    assign sa_rows[3] = sa_C3;

    tile_accumulator u_acc (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (accept),
        .add_en  (state == CAPTURE),
        .add_row (sa_rows),
        .rd_row  (step[1:0]),
        .rd_data (acc_row)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // Next-state logic. A zero-chunk tile skips straight to writing zeros.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = (k_chunks == 8'd0) ? WRITE : FETCH;
            FETCH:   if (step == 3'(FETCH_CYCLES - 1)) next_state = ARM;
            ARM:     next_state = RUN;
            RUN:     if (sa_done) next_state = CAPTURE;
            CAPTURE: next_state = more_chunks ? FETCH : WRITE;
            WRITE:   if (step == 3'(SA_DIM - 1)) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Outputs decode from the state so an async reset clears them at once.
    always_comb begin
        done            = 1'b0;
        sa_rst_n        = 1'b0;
        gbuf.A_index    = '0;
        gbuf.B_index    = '0;
        gbuf.C_wr_en    = 1'b0;
        gbuf.C_index    = '0;
        gbuf.C_data_out = '0;
        case (state)
            FETCH: begin
                if (step < 3'(SA_DIM)) begin
                    gbuf.A_index = a_reg + chunk_offset + ADDR_BITS'(step);
                    gbuf.B_index = b_reg + chunk_offset + ADDR_BITS'(step);
                end
            end
            RUN:   sa_rst_n = 1'b1;
            WRITE: begin
                gbuf.C_wr_en    = 1'b1;
                gbuf.C_index    = c_reg + ADDR_BITS'(step[1:0]);
                gbuf.C_data_out = DATAC_BITS'(acc_row);
            end
            DONE:  done = 1'b1;
            default: ;
        endcase
        busy = (state != IDLE);
    end

    assign sa_busy = busy;

    // Tile parameters, chunk/step counters and operand capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step  <= '0;
            chunk <= '0;
            k_reg <= '0;
            a_reg <= '0;
            b_reg <= '0;
            c_reg <= '0;
            for (int j = 0; j < SA_DIM; j++) begin
                op_a[j] <= '0;
                op_b[j] <= '0;
            end
        end else begin
            if (accept) begin
                k_reg <= k_chunks;
                a_reg <= a_base;
                b_reg <= b_base;
                c_reg <= c_base;
                chunk <= '0;
            end else if (state == CAPTURE && more_chunks) begin
                chunk <= chunk + 8'd1;
            end

            if (state != next_state)                    step <= '0;
            else if (state == FETCH || state == WRITE) step <= step + 3'd1;
            else                                       step <= '0;

            if (state == FETCH && step != 3'd0) begin
                op_a[slot] <= gbuf.A_data_in;
                op_b[slot] <= gbuf.B_data_in;
            end
        end
    end

    assign sa_A0 = op_a[0];
    assign sa_A1 = op_a[1];
    assign sa_A2 = op_a[2];
    assign sa_A3 = op_a[3];
    assign sa_B0 = op_b[0];
    assign sa_B1 = op_b[1];
    assign sa_B2 = op_b[2];
    assign sa_B3 = op_b[3];

endmodule

// File: tb/tb_sa_tile_ctrl.sv
// tb_sa_tile_ctrl
// Randomised bench for sa_tile_ctrl: a buffer model and an array model
// respond to the DUT, a tile-level reference model predicts every C write,
// operand set and done pulse, and monitors pop those predictions.
module tb_sa_tile_ctrl;

    typedef struct {
        logic [15:0]  idx;
        logic [127:0] data;
    } wr_t;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [7:0]   k_chunks;
    logic [15:0]  a_base, b_base, c_base;
    logic         busy, done, sa_rst_n, sa_busy, sa_done;
    logic [31:0]  sa_a [4];
    logic [31:0]  sa_b [4];
    logic [127:0] sa_c [4];

    sa_tile_ctrl_if #(.ADDR_BITS(16), .DATA_BITS(32), .DATAC_BITS(128)) gbuf_if ();

    sa_tile_ctrl #(.ADDR_BITS(16), .DATA_BITS(32), .DATAC_BITS(128)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .k_chunks(k_chunks),
        .a_base(a_base), .b_base(b_base), .c_base(c_base),
        .busy(busy), .done(done), .gbuf(gbuf_if),
        .sa_rst_n(sa_rst_n), .sa_busy(sa_busy),
        .sa_A0(sa_a[0]), .sa_A1(sa_a[1]), .sa_A2(sa_a[2]), .sa_A3(sa_a[3]),
        .sa_B0(sa_b[0]), .sa_B1(sa_b[1]), .sa_B2(sa_b[2]), .sa_B3(sa_b[3]),
        .sa_done(sa_done),
        .sa_C0(sa_c[0]), .sa_C1(sa_c[1]), .sa_C2(sa_c[2]), .sa_C3(sa_c[3])
    );

    // Scoreboard state shared between stimulus and monitors.
    wr_t          wr_q [$];
    logic [255:0] op_q [$];
    int           exp_done;
    int           errors;
    int           checks;

    logic [31:0]  memA [65536];
    logic [31:0]  memB [65536];
    int           tile_mode;
    int           pass_idx;
    int           run_sum;
    int           rise_cnt;
    logic [31:0]  fixed_val [8];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [255:0] actual,
                               input logic [255:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Signed int8 matrix product of one A row with the four B rows.
    // Byte k of a word sits at bits [31-8k -: 8]; lane l of a row at [127-32l -: 32].
    function automatic logic [127:0] product_row(input logic [31:0] a_row,
            input logic [31:0] b0, input logic [31:0] b1,
            input logic [31:0] b2, input logic [31:0] b3);
        logic [31:0]  b [4];
        logic [7:0]   ab, bbyte;
        logic [31:0]  av, bv, s;
        logic [127:0] row;
        b = '{b0, b1, b2, b3};
        row = '0;
        for (int l = 0; l < 4; l++) begin
            s = '0;
            for (int k = 0; k < 4; k++) begin
                ab    = a_row[31-8*k -: 8];
                bbyte = b[k][31-8*l -: 8];
                av    = {{24{ab[7]}}, ab};
                bv    = {{24{bbyte[7]}}, bbyte};
                s     = s + av * bv;
            end
            row[127-32*l -: 32] = s;
        end
        return row;
    endfunction

    // Buffer model: data for the index shown in one cycle appears in the next.
    initial begin : buffer_model
        logic [15:0] prev_a, prev_b;
        prev_a = '0;
        prev_b = '0;
        gbuf_if.A_data_in = '0;
        gbuf_if.B_data_in = '0;
        forever begin
            @(negedge clk);
            gbuf_if.A_data_in = memA[prev_a];
            gbuf_if.B_data_in = memB[prev_b];
            prev_a = gbuf_if.A_index;
            prev_b = gbuf_if.B_index;
        end
    end

    // Array model: random pass time, result from the held operands (mode 0)
    // or a per-pass constant in every lane (mode 1). Stray sa_done pulses
    // are thrown in whenever the array is held in reset.
    initial begin : array_model
        logic prev_run;
        int   run_cnt, t_run;
        prev_run = 1'b0;
        run_cnt  = 0;
        t_run    = 1;
        sa_done  = 1'b0;
        for (int r = 0; r < 4; r++) sa_c[r] = '0;
        forever begin
            @(negedge clk);
            if (sa_rst_n === 1'b1) begin
                if (!prev_run) begin
                    rise_cnt++;
                    t_run   = $urandom_range(1, 6);
                    run_cnt = 0;
                    if (op_q.size() == 0) begin
                        checkOutput("pass_expected", 256'(0), 256'(1));
                    end else begin
                        checkOutput("operands",
                            {sa_a[0], sa_a[1], sa_a[2], sa_a[3], sa_b[0], sa_b[1], sa_b[2], sa_b[3]},
                            op_q.pop_front());
                    end
                end
                run_cnt++;
                if (run_cnt == t_run) begin
                    sa_done = 1'b1;
                    for (int r = 0; r < 4; r++) begin
                        if (tile_mode == 0)
                            sa_c[r] = product_row(sa_a[r], sa_b[0], sa_b[1], sa_b[2], sa_b[3]);
                        else
                            sa_c[r] = {4{fixed_val[pass_idx % 8]}};
                    end
                    pass_idx++;
                    run_sum += t_run;
                end else begin
                    sa_done = 1'b0;
                end
            end else begin
                sa_done = ($urandom_range(0, 3) == 0);
            end
            prev_run = (sa_rst_n === 1'b1);
        end
    end

    // Output monitor: every C write and done pulse must match a prediction.
    initial begin : monitor
        wr_t exp;
        forever begin
            @(negedge clk);
            if (done || gbuf_if.C_wr_en)
                checkOutput("done_write_exclusive", 256'(done & gbuf_if.C_wr_en), 256'(0));
            if (gbuf_if.C_wr_en) begin
                if (wr_q.size() == 0) begin
                    checkOutput("write_expected", 256'(0), 256'(1));
                end else begin
                    exp = wr_q.pop_front();
                    checkOutput("c_index", 256'(gbuf_if.C_index), 256'(exp.idx));
                    checkOutput("c_data", 256'(gbuf_if.C_data_out), 256'(exp.data));
                end
            end
            if (done) begin
                checkOutput("done_expected", 256'(exp_done > 0), 256'(1));
                if (exp_done > 0) exp_done--;
            end
        end
    end

    // Predicts the tile from the buffer contents, launches it, and optionally
    // fires a stray start during RUN or an async reset during pass abort_pass.
    task automatic applyStimulus(input int k, input logic [15:0] ab, input logic [15:0] bb,
                                 input logic [15:0] cb, input int mode, input bit fill,
                                 input bit inject, input int abort_pass);
        logic [127:0] acc [4];
        logic [127:0] add;
        logic [31:0]  aw [4];
        logic [31:0]  bw [4];
        logic [15:0]  ad, bd;
        int           cyc, rises;
        bit           got_done, aborted, injected, prev_run;

        tile_mode = mode;
        pass_idx  = 0;
        run_sum   = 0;
        rise_cnt  = 0;
        for (int r = 0; r < 4; r++) acc[r] = '0;

        for (int c = 0; c < k; c++) begin
            for (int j = 0; j < 4; j++) begin
                ad = ab + 16'(4*c + j);
                bd = bb + 16'(4*c + j);
                if (fill) begin
                    memA[ad] = $urandom;
                    memB[bd] = $urandom;
                end
                aw[j] = memA[ad];
                bw[j] = memB[bd];
            end
            op_q.push_back({aw[0], aw[1], aw[2], aw[3], bw[0], bw[1], bw[2], bw[3]});
            for (int r = 0; r < 4; r++) begin
                add = (mode == 0) ? product_row(aw[r], bw[0], bw[1], bw[2], bw[3])
                                  : {4{fixed_val[c % 8]}};
                for (int l = 0; l < 4; l++)
                    acc[r][127-32*l -: 32] = acc[r][127-32*l -: 32] + add[127-32*l -: 32];
            end
        end
        for (int r = 0; r < 4; r++) wr_q.push_back('{idx: cb + 16'(r), data: acc[r]});
        exp_done++;

        @(negedge clk);
        start    = 1'b1;
        k_chunks = 8'(k);
        a_base   = ab;
        b_base   = bb;
        c_base   = cb;
        cyc      = 1;
        rises    = 0;
        got_done = 1'b0;
        aborted  = 1'b0;
        injected = 1'b0;
        prev_run = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            start    = 1'b0;
            k_chunks = 8'($urandom);
            a_base   = 16'($urandom);
            b_base   = 16'($urandom);
            c_base   = 16'($urandom);
            cyc++;
            if (sa_rst_n === 1'b1 && !prev_run) rises++;
            prev_run = (sa_rst_n === 1'b1);
            if (inject && !injected && sa_rst_n === 1'b1) begin
                start    = 1'b1;
                k_chunks = 8'd7;
                injected = 1'b1;
            end
            if (abort_pass >= 0 && rises == abort_pass + 1 && sa_rst_n === 1'b1) begin
                rst_n = 1'b0;
                #1;
                checkOutput("async_reset_outputs",
                    256'({busy, done, sa_rst_n, sa_busy, gbuf_if.C_wr_en, gbuf_if.C_index,
                          gbuf_if.A_index, gbuf_if.B_index, sa_a[0], sa_b[3], gbuf_if.C_data_out}),
                    256'(0));
                wr_q.delete();
                op_q.delete();
                exp_done = 0;
                repeat (4) @(negedge clk);
                rst_n   = 1'b1;
                aborted = 1'b1;
                break;
            end
            if (done) begin
                got_done = 1'b1;
                break;
            end
        end
        start = 1'b0;
        if (aborted) return;
        if (!got_done) begin
            checkOutput("done_timeout", 256'(0), 256'(1));
            return;
        end
        checkOutput("latency", 256'(cyc), 256'(1 + 7*k + run_sum + 5));
        @(negedge clk);
        checkOutput("busy_after_done", 256'(busy), 256'(0));
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        exp_done  = 0;
        tile_mode = 0;
        pass_idx  = 0;
        run_sum   = 0;
        rise_cnt  = 0;
        rst_n     = 1'b0;
        start     = 1'b0;
        k_chunks  = '0;
        a_base    = '0;
        b_base    = '0;
        c_base    = '0;
        for (int i = 0; i < 8; i++) fixed_val[i] = '0;

        repeat (3) @(negedge clk);
        checkOutput("reset_ctrl", 256'({busy, done, sa_rst_n, sa_busy, gbuf_if.C_wr_en}), 256'(0));
        checkOutput("reset_index", 256'({gbuf_if.A_index, gbuf_if.B_index, gbuf_if.C_index}), 256'(0));
        checkOutput("reset_cdata", 256'(gbuf_if.C_data_out), 256'(0));
        checkOutput("reset_operands",
            {sa_a[0], sa_a[1], sa_a[2], sa_a[3], sa_b[0], sa_b[1], sa_b[2], sa_b[3]}, 256'(0));
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("[TB] identity tile");
        for (int j = 0; j < 4; j++) begin
            memA[16'h0100 + 16'(j)] = 32'h0100_0000 >> (8*j);
            memB[16'h0200 + 16'(j)] = {8'(4*j+1), 8'(4*j+2), 8'(4*j+3), 8'(4*j+4)};
        end
        applyStimulus(1, 16'h0100, 16'h0200, 16'h0040, 0, 1'b0, 1'b0, -1);

        $display("[TB] accumulation over 3 chunks");
        for (int i = 0; i < 8; i++) fixed_val[i] = 32'd5;
        applyStimulus(3, 16'h1000, 16'h2000, 16'h0300, 1, 1'b1, 1'b0, -1);
        checkOutput("arm_pulses", 256'(rise_cnt), 256'(3));

        $display("[TB] zero chunks");
        applyStimulus(0, 16'h1234, 16'h5678, 16'h0500, 0, 1'b1, 1'b0, -1);
        checkOutput("no_array_run", 256'(rise_cnt), 256'(0));

        $display("[TB] wrap of lanes and indices");
        fixed_val[0] = 32'hFFFF_FFF0;
        fixed_val[1] = 32'h0000_0020;
        applyStimulus(2, 16'hFFFE, 16'hFFFD, 16'hFFFE, 1, 1'b1, 1'b0, -1);

        $display("[TB] start during RUN");
        applyStimulus(2, 16'h0700, 16'h0800, 16'h0900, 0, 1'b1, 1'b1, -1);
        repeat (12) @(negedge clk);
        checkOutput("idle_after_ignored_start", 256'(busy), 256'(0));

        $display("[TB] reset during chunk 1 of 2");
        applyStimulus(2, 16'h0A00, 16'h0B00, 16'h0C00, 0, 1'b1, 1'b0, 1);
        repeat (3) @(negedge clk);
        applyStimulus(2, 16'h0A10, 16'h0B10, 16'h0C10, 0, 1'b1, 1'b0, -1);

        $display("[TB] random tiles");
        for (int t = 0; t < 6; t++) begin
            applyStimulus($urandom_range(1, 3), 16'($urandom), 16'($urandom), 16'($urandom),
                          0, 1'b1, (t % 3) == 0, -1);
        end

        repeat (12) @(negedge clk);
        checkOutput("leftover_writes", 256'(wr_q.size()), 256'(0));
        checkOutput("leftover_done", 256'(exp_done), 256'(0));
        checkOutput("leftover_passes", 256'(op_q.size()), 256'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sa_tile_ctrl.md
# sa_tile_ctrl

Tile controller directly upstream and downstream of the 4×4 int8 systolic array. It computes one 4×4 output tile at a time:
- fetches 4 A words and 4 B words per K-chunk from the global buffers;
- presents them to the array and pulses the array reset around each pass;
- accumulates the array's 32-bit results across K-chunks;
- writes the four 128-bit result rows to global buffer C.

## Interface
Parameters:
- ADDR_BITS, 16, global buffer index width
- DATA_BITS, 32, A/B word width (4 × int8)
- DATAC_BITS, 128, C row width (4 × 32-bit lanes)

Ports:
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  begin tile; sampled only in IDLE
- k_chunks  in  8  number of 4-deep K passes; sampled with start
- a_base, b_base, c_base  in  ADDR_BITS each  base indices; sampled with start
- busy  out  1  high from the cycle after start is accepted until IDLE
- done  out  1  one-cycle pulse after the last C write
- A_index, B_index  out  ADDR_BITS  global buffer read index
- A_data_in, B_data_in  in  DATA_BITS  read data, valid one cycle after the index
- C_wr_en  out  1  C write strobe
- C_index  out  ADDR_BITS  C write index
- C_data_out  out  DATAC_BITS  C write data
- sa_rst_n  out  1  array reset, active-low
- sa_busy  out  1  mirror of busy
- sa_A0..sa_A3, sa_B0..sa_B3  out  DATA_BITS  operand words to the array
- sa_done  in  1  array pass complete
- sa_C0..sa_C3  in  DATAC_BITS  array result rows

## Operation
State sequence: IDLE → FETCH → ARM → RUN → CAPTURE → (FETCH | WRITE) → DONE → IDLE.

- **IDLE:** sa_rst_n=0. On start=1, latch the bases and k_chunks, clear accumulators, clear the chunk counter.
  - k_chunks=0 → go to WRITE (writes four all-zero rows).
  - Otherwise → FETCH.
- **FETCH:** 5 cycles.
  - Cycles 0–3: A_index = a_base + 4·chunk + j and B_index = b_base + 4·chunk + j, for j = 0..3.
  - Cycles 1–4: register the returned data into sa_Aj / sa_Bj.
- **ARM:** 1 cycle, sa_rst_n=0. Clears the PEs; operand registers stay stable.
- **RUN:** sa_rst_n=1. Operand registers are held constant. Stay until sa_done=1 is sampled.
- **CAPTURE:** 1 cycle, sa_rst_n=0.
  - Lane-wise add: acc[r][l] += sa_Cr[l], modulo 2^32.
  - Lane l occupies bits [127−32l : 96−32l], so column 0 is in the MSBs.
  - chunk+1 < k_chunks → increment chunk, go to FETCH. Otherwise → WRITE.
- **WRITE:** 4 cycles. C_wr_en=1, C_index = c_base + r, C_data_out = acc[r], for r = 0..3.
- **DONE:** done=1 for 1 cycle, then IDLE.

Index arithmetic wraps modulo 2^ADDR_BITS.

## Timing
- **Reset values:** busy=0, done=0, C_wr_en=0, C_index=0, C_data_out=0, A_index=0, B_index=0, sa_rst_n=0, sa_A*/sa_B*=0, accumulators=0, state=IDLE.
- **Start:** accepted at the rising edge where state=IDLE. busy=1 from the next cycle. A_index is valid in that same cycle.
- **start while busy:** ignored, not queued.
- **Latency, k_chunks=N≥1:** 1 + N·(5 + 1 + T_run + 1) + 4 + 1 cycles from start to done, where T_run is the array pass time.
- **Latency, k_chunks=0:** done 6 cycles after start.
- **sa_done timing:**
  - sa_done sampled in RUN moves to CAPTURE on that edge.
  - sa_Cr are sampled in CAPTURE, one cycle later.
  - sa_done outside RUN is ignored.
- **Async reset mid-operation:** all outputs return to reset values immediately. No C write completes after rst_n falls. Any partial tile is discarded.
- C_wr_en is never high outside WRITE. done and C_wr_en are never high together.

## Structure
- **Package tpu_pkg:**
  - state enum (IDLE, FETCH, ARM, RUN, CAPTURE, WRITE, DONE)
  - SA_DIM=4
  - LANE_BITS=32
  - FETCH_CYCLES=5
  - lane-slice helper function
- **Sub-module tile_accumulator:**
  - 4×DATAC_BITS registers with clear, lane-wise add-enable, and a row read port.
  - Instantiated once.
- FSM, counters and the address generator stay in sa_tile_ctrl.

## Test plan
- **Identity tile:** A = I, B rows = 1..16, k_chunks=1, c_base=0x40; array model returns A·B.
  - Expect rows 0x40..0x43 equal to B's rows widened to 32-bit lanes, then a done pulse.
- **Accumulation:** k_chunks=3, every pass returns all lanes = 5.
  - Expect every written lane = 15.
  - Exactly 3 ARM pulses on sa_rst_n.
  - A_index for chunk 2 starts at a_base+8.
- **k_chunks=0:**
  - Expect 4 writes of 0 at c_base..c_base+3.
  - done 6 cycles after start; sa_rst_n never rises.
- **Wrap:** accumulated lane 0xFFFFFFF0 + 0x20 → 0x00000010; a_base = 0xFFFE → indices 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- **start asserted during RUN:** no restart; k_chunks and bases unchanged; exactly one done.
- **rst_n low during RUN of chunk 1 of 2:**
  - Outputs reset immediately, no C writes.
  - A new start afterwards yields correct results.
